// File: rtl/mxu_result_drain.sv
// mxu_result_drain: captures an MXU result matrix and streams it out row by row, requantized
module mxu_result_drain #(
   parameter int DIM           = 16,
   parameter int BIT_WIDTH     = 4,
   parameter int OUT_BIT_WIDTH = 2 * BIT_WIDTH,
   parameter int A_ROW         = DIM,
   parameter int B_COL         = DIM
) (
   input  logic                                           clk,
   input  logic                                           reset_n,
   input  logic                                           in_valid,
   input  logic [A_ROW-1:0][B_COL-1:0][OUT_BIT_WIDTH-1:0] in_data,
   input  logic [$clog2(OUT_BIT_WIDTH)-1:0]               shift,
   input  logic                                           row_ready,
   input  logic                                           clr_overflow,
   output logic                                           row_valid,
   output logic [B_COL-1:0][BIT_WIDTH-1:0]                row_data,
   output logic [$clog2(A_ROW)-1:0]                       row_index,
   output logic                                           row_last,
   output logic                                           busy,
   output logic                                           done,
   output logic                                           overflow
);
   localparam int IW = $clog2(A_ROW);
   localparam int SW = $clog2(OUT_BIT_WIDTH);
   localparam logic signed [OUT_BIT_WIDTH-1:0] SAT_MAX = OUT_BIT_WIDTH'((1 << (BIT_WIDTH - 1)) - 1);
   localparam logic signed [OUT_BIT_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
   typedef enum logic {IDLE, DRAIN} state_t;
   state_t                                           state_q, state_d;
   logic                                             in_valid_q;
   logic [A_ROW-1:0][B_COL-1:0][OUT_BIT_WIDTH-1:0]   buf_q, buf_d;
   logic [SW-1:0]                                    shift_q, shift_d;
   logic [IW-1:0]                                    idx_q, idx_d;
   logic                                             done_q, done_d;
   logic                                             ovf_q, ovf_d;
   logic                                             rise, last, xfer, capture;
   logic signed [OUT_BIT_WIDTH-1:0]                  sh;
   // A rise may be taken when idle, or in the same cycle the final row leaves
   always_comb begin
      rise    = in_valid & ~in_valid_q;
      last    = (state_q == DRAIN) && (idx_q == IW'(A_ROW - 1));
      xfer    = (state_q == DRAIN) && row_ready;
      capture = rise && ((state_q == IDLE) || (xfer && last));
   end
   // Next-state: capture restarts the drain at row 0, otherwise advance on each transfer
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      done_d  = xfer && last;
      ovf_d   = (rise && (state_q == DRAIN) && !(xfer && last)) || (ovf_q && !clr_overflow);
      if (capture) begin
         buf_d   = in_data;
         shift_d = shift;
         idx_d   = '0;
         state_d = DRAIN;
      end else if (xfer) begin
         idx_d   = last ? '0 : idx_q + 1'b1;
         state_d = last ? IDLE : DRAIN;
      end
   end
   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         in_valid_q <= 1'b0;
         buf_q      <= '0;
         shift_q    <= '0;
         idx_q      <= '0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_valid_q <= in_valid;
         buf_q      <= buf_d;
         shift_q    <= shift_d;
         idx_q      <= idx_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
      end
   end
   // Requantize the presented row: arithmetic shift then saturate to the narrow range
   always_comb begin
      sh       = '0;
      row_data = '0;
      for (int c = 0; c < B_COL; c++) begin
         sh          = $signed(buf_q[idx_q][c]) >>> shift_q;
         row_data[c] = (sh > SAT_MAX) ? SAT_MAX[BIT_WIDTH-1:0] :
                       (sh < SAT_MIN) ? SAT_MIN[BIT_WIDTH-1:0] : sh[BIT_WIDTH-1:0];
      end
   end
   assign row_valid = (state_q == DRAIN);
   assign busy      = (state_q == DRAIN);
   assign row_index = idx_q;
   assign row_last  = last;
   assign done      = done_q;
   assign overflow  = ovf_q;
endmodule

// File: tb/tb_mxu_result_drain.sv
// tb_mxu_result_drain: directed self-checking bench for mxu_result_drain (DIM=4, BIT_WIDTH=4)
module tb_mxu_result_drain;
   logic                  clk = 1'b0;
   logic                  reset_n = 1'b0;
   logic                  in_valid = 1'b0;
   logic [3:0][3:0][7:0]  in_data = '0;
   logic [2:0]            shift = '0;
   logic                  row_ready = 1'b1;
   logic                  clr_overflow = 1'b0;
   logic                  row_valid;
   logic [3:0][3:0]       row_data;
   logic [1:0]            row_index;
   logic                  row_last, busy, done, overflow;
   int                    checks = 0;
   int                    errors = 0;

   mxu_result_drain #(.DIM(4), .BIT_WIDTH(4)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .shift(shift),
      .row_ready(row_ready), .clr_overflow(clr_overflow), .row_valid(row_valid), .row_data(row_data),
      .row_index(row_index), .row_last(row_last), .busy(busy), .done(done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic fill_all(input logic [7:0] v, input logic [2:0] s);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            in_data[r][c] = v;
      shift = s;
   endtask

   task automatic fill_rows();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            in_data[r][c] = 8'(r + 1);
      shift = 3'd0;
   endtask

   // Raise in_valid for one cycle; returns at the negedge where row 0 is presented
   task automatic pulse();
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({row_valid, busy, done, overflow, row_last, row_index, row_data} !== 23'd0) begin
         errors++;
         $display("FAIL reset_state got %h exp 0", {row_valid, busy, done, overflow, row_last, row_index, row_data});
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      row_ready = 1'b1;
      fill_all(8'd5, 3'd0);
      pulse();
      for (int r = 0; r < 4; r++) begin
         checks++;
         if ({row_valid, busy, done, row_index, row_last, row_data} !== {3'b110, 2'(r), r == 3, 16'h5555}) begin
            errors++;
            $display("FAIL basic_row%0d got v%b b%b d%b i%0d l%b %h exp v1 b1 d0 i%0d l%b 5555",
                     r, row_valid, busy, done, row_index, row_last, row_data, r, r == 3);
         end
         @(negedge clk);
      end
      checks++;
      if ({done, row_valid, busy} !== 3'b100) begin
         errors++;
         $display("FAIL basic_done got d%b v%b b%b exp d1 v0 b0", done, row_valid, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_width got %b exp 0", done);
      end
   endtask

   task automatic test_quant();
      logic [7:0] vals [4] = '{8'd100, 8'hC0, 8'hF7, 8'hFF};
      logic [2:0] shs  [4] = '{3'd2, 3'd3, 3'd0, 3'd1};
      logic [3:0] exps [4] = '{4'h7, 4'h8, 4'h8, 4'hF};
      for (int k = 0; k < 4; k++) begin
         fill_all(vals[k], shs[k]);
         pulse();
         checks++;
         if (row_data !== {4{exps[k]}}) begin
            errors++;
            $display("FAIL quant_%0d got %h exp %h", k, row_data, {4{exps[k]}});
         end
         repeat (5) @(negedge clk);
      end
   endtask

   task automatic test_stall();
      fill_rows();
      pulse();
      @(negedge clk);
      row_ready = 1'b0;
      fill_all(8'h70, 3'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({row_valid, row_index, row_last, row_data} !== {1'b1, 2'd1, 1'b0, 16'h2222}) begin
            errors++;
            $display("FAIL stall_%0d got v%b i%0d l%b %h exp v1 i1 l0 2222", i, row_valid, row_index, row_last, row_data);
         end
      end
      row_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({row_index, row_data} !== {2'd2, 16'h3333}) begin
         errors++;
         $display("FAIL stall_resume got i%0d %h exp i2 3333", row_index, row_data);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_overflow();
      fill_rows();
      pulse();
      repeat (2) @(negedge clk);
      fill_all(8'h11, 3'd0);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if ({overflow, row_index, row_data} !== {1'b1, 2'd3, 16'h4444}) begin
         errors++;
         $display("FAIL ovf_set got o%b i%0d %h exp o1 i3 4444", overflow, row_index, row_data);
      end
      @(negedge clk);
      checks++;
      if ({done, busy, overflow} !== 3'b101) begin
         errors++;
         $display("FAIL ovf_dropped got d%b b%b o%b exp d1 b0 o1", done, busy, overflow);
      end
      clr_overflow = 1'b1;
      @(negedge clk);
      clr_overflow = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear got %b exp 0", overflow);
      end
   endtask

   task automatic test_level();
      int nv = 0;
      int nd = 0;
      fill_all(8'd5, 3'd0);
      in_valid = 1'b1;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (i == 9) in_valid = 1'b0;
         nv += int'(row_valid);
         nd += int'(done);
      end
      checks++;
      if (nv != 4 || nd != 1) begin
         errors++;
         $display("FAIL level_single got rows %0d dones %0d exp rows 4 dones 1", nv, nd);
      end
   endtask

   task automatic test_back_to_back();
      fill_rows();
      pulse();
      repeat (3) @(negedge clk);
      fill_all(8'd3, 3'd0);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if ({busy, done, overflow, row_index, row_data} !== {3'b110, 2'd0, 16'h3333}) begin
         errors++;
         $display("FAIL b2b_capture got b%b d%b o%b i%0d %h exp b1 d1 o0 i0 3333", busy, done, overflow, row_index, row_data);
      end
      repeat (4) @(negedge clk);
      checks++;
      if ({done, busy} !== 2'b10) begin
         errors++;
         $display("FAIL b2b_done got d%b b%b exp d1 b0", done, busy);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int nd = 0;
      fill_rows();
      pulse();
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({row_valid, busy, done, overflow, row_last, row_index, row_data} !== 23'd0) begin
         errors++;
         $display("FAIL mid_reset got %h exp 0", {row_valid, busy, done, overflow, row_last, row_index, row_data});
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         nd += int'(done);
      end
      checks++;
      if (nd != 0) begin
         errors++;
         $display("FAIL mid_no_done got %0d exp 0", nd);
      end
      fill_all(8'd5, 3'd0);
      pulse();
      checks++;
      if ({row_valid, row_index, row_data} !== {1'b1, 2'd0, 16'h5555}) begin
         errors++;
         $display("FAIL mid_restart got v%b i%0d %h exp v1 i0 5555", row_valid, row_index, row_data);
      end
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if ({row_valid, row_index} !== {1'b1, 2'd0}) begin
         errors++;
         $display("FAIL high_at_release got v%b i%0d exp v1 i0", row_valid, row_index);
      end
      repeat (5) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_quant();
      test_stall();
      test_overflow();
      test_level();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
